// File: rtl/vx_tag_flush_ctrl.sv
// vx_tag_flush_ctrl
// Per-bank sequencer in front of the tag store access stage. After reset and
// after every accepted flush request it walks all lines of the bank, issuing
// one invalidating fill per cycle. While idle, pipeline requests pass straight
// through to the tag stage with no added latency.
module vx_tag_flush_ctrl #(
  parameter int CACHE_ID         = 0,
  parameter int BANK_ID          = 0,
  parameter int CACHE_SIZE       = 16384,
  parameter int CACHE_LINE_SIZE  = 64,
  parameter int NUM_BANKS        = 4,
  parameter int WORD_SIZE        = 4,
  parameter int BANK_ADDR_OFFSET = 0,
  parameter int LINE_ADDR_WIDTH  = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_req_valid,
  output logic                       flush_req_ready,
  input  logic                       core_valid,
  input  logic                       core_fill,
  input  logic [LINE_ADDR_WIDTH-1:0] core_addr,
  output logic                       core_ready,
  output logic                       tag_lookup,
  output logic                       tag_fill,
  output logic                       tag_is_flush,
  output logic [LINE_ADDR_WIDTH-1:0] tag_addr,
  output logic                       busy,
  output logic                       flush_done
);

  localparam int LINES_PER_BANK = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS);
  localparam int CNT_W          = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINES_PER_BANK - 1);

  // Reject configurations the walk cannot address; the id/offset values are
  // debug-only and merely checked for sanity here.
  if (LINES_PER_BANK < 1 || LINE_ADDR_WIDTH < CNT_W || WORD_SIZE > CACHE_LINE_SIZE ||
      CACHE_ID < 0 || BANK_ID < 0 || BANK_ADDR_OFFSET < 0) begin : g_bad_params
    $error("vx_tag_flush_ctrl: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                       state_r;
  state_t                       state_next_s;
  logic [CNT_W-1:0]             cnt_r;
  logic [CNT_W-1:0]             cnt_next_s;

  logic                         flush_req_ready_s;
  logic                         core_ready_s;
  logic                         tag_lookup_s;
  logic                         tag_fill_s;
  logic                         tag_is_flush_s;
  logic [LINE_ADDR_WIDTH-1:0]   tag_addr_s;
  logic                         busy_s;
  logic                         flush_done_s;

  // State and line counter registers; reset restarts the init walk at line 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_INIT;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic plus tag-stage control decode from the registered state.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    flush_req_ready_s = 1'b0;
    core_ready_s      = 1'b0;
    tag_lookup_s      = 1'b0;
    tag_fill_s        = 1'b0;
    tag_is_flush_s    = 1'b0;
    tag_addr_s        = {LINE_ADDR_WIDTH{1'b0}};
    busy_s            = 1'b1;
    flush_done_s      = 1'b0;

    case (state_r)
      S_INIT, S_FLUSH: begin
        // Walk: invalidate one line per cycle; tag bits stay zero.
        tag_fill_s     = 1'b1;
        tag_is_flush_s = 1'b1;
        tag_addr_s     = LINE_ADDR_WIDTH'(cnt_r);
        if (cnt_r == CNT_LAST) begin
          cnt_next_s   = {CNT_W{1'b0}};
          state_next_s = (state_r == S_INIT) ? S_IDLE : S_DONE;
        end else begin
          cnt_next_s   = cnt_r + CNT_W'(1);
        end
      end
      S_IDLE: begin
        busy_s            = 1'b0;
        flush_req_ready_s = 1'b1;
        // A pending flush wins over the pipeline request in the same cycle.
        core_ready_s      = ~flush_req_valid;
        if (flush_req_valid) begin
          state_next_s = S_FLUSH;
          cnt_next_s   = {CNT_W{1'b0}};
        end else begin
          tag_lookup_s = core_valid & ~core_fill;
          tag_fill_s   = core_valid & core_fill;
          tag_addr_s   = core_addr;
        end
      end
      S_DONE: begin
        flush_done_s = 1'b1;
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_INIT;
        cnt_next_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // While reset is high every control is forced quiet and busy is reported.
  assign flush_req_ready = flush_req_ready_s & ~reset;
  assign core_ready      = core_ready_s & ~reset;
  assign tag_lookup      = tag_lookup_s & ~reset;
  assign tag_fill        = tag_fill_s & ~reset;
  assign tag_is_flush    = tag_is_flush_s & ~reset;
  assign tag_addr        = tag_addr_s;
  assign busy            = busy_s | reset;
  assign flush_done      = flush_done_s & ~reset;

endmodule

// File: tb/tb_vx_tag_flush_ctrl.sv
// Self-checking bench for vx_tag_flush_ctrl. A schedule-based reference model
// predicts every tag-stage operation and completion pulse with its cycle
// number; a monitor compares them as the DUT presents them.
module tb_vx_tag_flush_ctrl;

  localparam int AW = 26;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush_req_valid = 1'b0;
  logic          flush_req_ready;
  logic          core_valid = 1'b0;
  logic          core_fill = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic          core_ready;
  logic          tag_lookup;
  logic          tag_fill;
  logic          tag_is_flush;
  logic [AW-1:0] tag_addr;
  logic          busy;
  logic          flush_done;

  always #5 clk = ~clk;

  vx_tag_flush_ctrl #(
    .CACHE_ID(0), .BANK_ID(0), .CACHE_SIZE(16384), .CACHE_LINE_SIZE(64),
    .NUM_BANKS(4), .WORD_SIZE(4), .BANK_ADDR_OFFSET(0), .LINE_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready),
    .core_valid(core_valid), .core_fill(core_fill), .core_addr(core_addr),
    .core_ready(core_ready),
    .tag_lookup(tag_lookup), .tag_fill(tag_fill), .tag_is_flush(tag_is_flush),
    .tag_addr(tag_addr), .busy(busy), .flush_done(flush_done)
  );

  typedef struct {
    int            cyc;
    logic          lk;
    logic          fl;
    logic          fs;
    logic          dn;
    logic [AW-1:0] addr;
  } ev_t;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  avail  = 0;   // first cycle in which the bank is idle again
  int  checks = 0;
  int  passes = 0;
  int  fails  = 0;

  function automatic void push_ev(int c, logic lk, logic fl, logic fs, logic dn,
                                  logic [AW-1:0] a);
    ev_t e;
    e.cyc = c; e.lk = lk; e.fl = fl; e.fs = fs; e.dn = dn; e.addr = a;
    exp_q.push_back(e);
  endfunction

  // A walk: one invalidating fill per line, lines 0..N-1 in consecutive cycles.
  function automatic void push_walk(int start);
    for (int i = 0; i < N; i++) push_ev(start + i, 1'b0, 1'b1, 1'b1, 1'b0, AW'(i));
  endfunction

  task automatic check1(input string name, input logic act, input logic expv);
    checks++;
    if (act === expv) passes++;
    else begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", name, cyc, act, expv);
    end
  endtask

  // Monitor: every presented tag operation or completion pulse must match the
  // oldest expectation, including the cycle it was due in.
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (tag_lookup || tag_fill || tag_is_flush || flush_done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d got lk=%0b fl=%0b fs=%0b dn=%0b addr=%h want none",
                 cyc, tag_lookup, tag_fill, tag_is_flush, flush_done, tag_addr);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc == cyc && e.lk === tag_lookup && e.fl === tag_fill &&
            e.fs === tag_is_flush && e.dn === flush_done &&
            (e.dn || e.addr === tag_addr)) begin
          passes++;
        end else begin
          fails++;
          $display("FAIL tag_event cyc=%0d got lk=%0b fl=%0b fs=%0b dn=%0b addr=%h want cyc=%0d lk=%0b fl=%0b fs=%0b dn=%0b addr=%h",
                   cyc, tag_lookup, tag_fill, tag_is_flush, flush_done, tag_addr,
                   e.cyc, e.lk, e.fl, e.fs, e.dn, e.addr);
        end
      end
    end
  end

  // One cycle of stimulus; called just after a rising edge.
  task automatic step(input logic fv, input logic cv, input logic cf, input logic [AW-1:0] a);
    bit idle;
    flush_req_valid = fv; core_valid = cv; core_fill = cf; core_addr = a;
    idle = (cyc >= avail);
    if (idle && fv) begin
      push_walk(cyc + 1);
      push_ev(cyc + N + 1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      avail = cyc + N + 2;
    end else if (idle && cv) begin
      push_ev(cyc, ~cf, cf, 1'b0, 1'b0, a);
    end
    @(negedge clk);
    check1("flush_req_ready", flush_req_ready, idle);
    check1("core_ready", core_ready, idle && !fv);
    check1("busy", busy, !idle);
    @(posedge clk); #1;
    cyc++;
  endtask

  // Hold reset for ncyc cycles with random inputs, then release into cycle 0.
  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    checks++;
    if (exp_q.size() == 0 || exp_q[0].cyc >= cyc) passes++;
    else begin
      fails++;
      $display("FAIL missed_event_before_reset cyc=%0d got pending_due=%0d want none", cyc, exp_q[0].cyc);
    end
    exp_q.delete();
    for (int i = 0; i < ncyc; i++) begin
      flush_req_valid = 1'($urandom); core_valid = 1'b1;
      core_fill = 1'($urandom); core_addr = AW'($urandom);
      @(negedge clk);
      check1("rst_tag_lookup", tag_lookup, 1'b0);
      check1("rst_tag_fill", tag_fill, 1'b0);
      check1("rst_tag_is_flush", tag_is_flush, 1'b0);
      check1("rst_core_ready", core_ready, 1'b0);
      check1("rst_flush_req_ready", flush_req_ready, 1'b0);
      check1("rst_flush_done", flush_done, 1'b0);
      check1("rst_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    cyc   = 0;
    avail = N;
    push_walk(0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && cyc < avail; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(3);

    // Init walk while the pipeline presents requests that must be held off.
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, 1'($urandom), AW'($urandom));

    // Pass-through lookup and fill in IDLE.
    step(1'b0, 1'b1, 1'b0, AW'(32'h1234));
    step(1'b0, 1'b1, 1'b1, AW'(32'h1234));
    step(1'b0, 1'b0, 1'b0, '0);

    // Plain flush handshake followed by the full walk and done pulse.
    step(1'b1, 1'b0, 1'b0, '0);
    wait_idle();
    step(1'b0, 1'b0, 1'b0, '0);

    // Simultaneous core and flush: core request held until IDLE returns.
    step(1'b1, 1'b1, 1'b0, AW'(32'h55));
    for (int i = 0; i < N + 2; i++) step(1'b0, 1'b1, 1'b0, AW'(32'h55));

    // Flush request held from reset release: accepted in the first IDLE cycle.
    do_reset(2);
    for (int i = 0; i <= N; i++) step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < N + 6; i++) step(1'b0, 1'b0, 1'b0, '0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), AW'($urandom));
    wait_idle();

    // Reset at line 20 of a flush: walk abandoned, no done, init restarts.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 21; i++) step(1'b0, 1'b0, 1'b0, '0);
    do_reset(2);
    for (int i = 0; i < N + 4; i++) step(1'b0, 1'($urandom), 1'($urandom), AW'($urandom));

    // Every predicted event must have been observed.
    checks++;
    if (exp_q.size() == 0) passes++;
    else begin
      fails++;
      $display("FAIL leftover_events cyc=%0d got pending=%0d want 0", cyc, exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
